bitsliced_result_collector: RTL and testbench

Downstream companion of the bit-sliced ALU. Captures the `Slice_Size`-bit result slices the ALU drives on `rd_d`, least-significant slice first, and reassembles them into a full `LENGTH`-bit word. It then presents the word, with its destination register address and flags, to the register-file writeback port under a valid/ready handshake. Slice capture strobes come from the slice controller, which already tracks `count`.

---
 rtl/bitsliced_result_collector.sv | 138 +++++++++++++
 tb/tb_bitsliced_result_collector.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bitsliced_result_collector.sv
// Bit-sliced result collector: reassembles ALU result slices (LSB first)
// into a full word and hands it to writeback under valid/ready.
module bitsliced_result_collector #(
  parameter int LENGTH     = 32,
  parameter int Slice_Size = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4:0]            rd_addr_in,
  input  logic                  abort,
  input  logic [Slice_Size-1:0] slice_in,
  input  logic                  slice_valid,
  output logic [LENGTH-1:0]     result,
  output logic [4:0]            rd_addr,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  zero,
  output logic                  busy,
  output logic                  overrun
);

  localparam int NSLICE = LENGTH / Slice_Size;
  localparam int CW     = $clog2(NSLICE) + 1;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [LENGTH-1:0] sr;
  logic [LENGTH-1:0] sr_shift;
  logic [CW-1:0]     cnt;
  logic              take;
  logic              last;
  logic              load;
  logic              drop;
  logic              release_word;

  assign sr_shift = {slice_in, sr[LENGTH-1:Slice_Size]};

  assign take = (state == COLLECT) && slice_valid;
  assign last = take && (cnt == CW'(NSLICE - 1));

  assign release_word = (state == HOLD) && result_ready;

  // A new word may begin from IDLE, or straight out of a released HOLD.
  assign load = start && ((state == IDLE) || release_word);

  // Slices only have a home while collecting; anything else is lost.
  assign drop = slice_valid && (state != COLLECT);

  assign busy = (state != IDLE);

  // Next-state selection; abort overrides everything.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start)
            state_nxt = COLLECT;
        end
        COLLECT: begin
          if (last)
            state_nxt = HOLD;
        end
        HOLD: begin
          if (result_ready)
            state_nxt = start ? COLLECT : IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Shift register, slice counter and destination address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr      <= '0;
      cnt     <= '0;
      rd_addr <= '0;
    end else if (abort) begin
      sr      <= '0;
      cnt     <= '0;
      rd_addr <= '0;
    end else if (load) begin
      sr      <= '0;
      cnt     <= '0;
      rd_addr <= rd_addr_in;
    end else if (take) begin
      sr      <= sr_shift;
      cnt     <= cnt + CW'(1);
    end
  end

  // Presented word, its flags and the valid half of the handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result       <= '0;
      zero         <= 1'b0;
      result_valid <= 1'b0;
    end else if (abort) begin
      result       <= '0;
      zero         <= 1'b0;
      result_valid <= 1'b0;
    end else if (last) begin
      result       <= sr_shift;
      zero         <= ~|sr_shift;
      result_valid <= 1'b1;
    end else if (release_word) begin
      result_valid <= 1'b0;
    end
  end

  // Sticky record of slices that arrived with nowhere to go.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      overrun <= 1'b0;
    else if (!abort && drop)
      overrun <= 1'b1;
  end

endmodule

// File: tb/tb_bitsliced_result_collector.sv
// Directed bench for bitsliced_result_collector.
// Hand-computed words, gaps, backpressure, back-to-back, abort and reset.
module tb_bitsliced_result_collector;

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  rd_addr_in;
  logic        abort;
  logic [3:0]  slice_in;
  logic        slice_valid;
  logic [31:0] result;
  logic [4:0]  rd_addr;
  logic        result_valid;
  logic        result_ready;
  logic        zero;
  logic        busy;
  logic        overrun;

  int checks;
  int errors;

  bitsliced_result_collector dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .rd_addr_in   (rd_addr_in),
    .abort        (abort),
    .slice_in     (slice_in),
    .slice_valid  (slice_valid),
    .result       (result),
    .rd_addr      (rd_addr),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .zero         (zero),
    .busy         (busy),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_word(input logic [4:0] a);
    start      = 1'b1;
    rd_addr_in = a;
    step();
    start      = 1'b0;
  endtask

  task automatic slice(input logic [3:0] v);
    slice_in    = v;
    slice_valid = 1'b1;
    step();
    slice_valid = 1'b0;
  endtask

  task automatic release_word();
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    check("release_valid", result_valid, 0);
    check("release_busy", busy, 0);
  endtask

  logic [31:0] w;
  int gaps [8] = '{0, 3, 1, 2, 0, 3, 2, 1};

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b0;
    start        = 1'b0;
    rd_addr_in   = '0;
    abort        = 1'b0;
    slice_in     = '0;
    slice_valid  = 1'b0;
    result_ready = 1'b0;

    #3;
    check("rst_result", result, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_valid", result_valid, 0);
    check("rst_zero", zero, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    step();
    step();
    reset = 1'b1;
    step();

    // 1: basic assembly of 0x12345678
    w = 32'h1234_5678;
    begin_word(5'd5);
    check("t1_busy", busy, 1);
    for (int i = 0; i < 8; i++) begin
      slice(w[4*i +: 4]);
      if (i < 7)
        check($sformatf("t1_early_%0d", i), result_valid, 0);
    end
    check("t1_valid", result_valid, 1);
    check("t1_result", result, 32'h1234_5678);
    check("t1_rd_addr", rd_addr, 5);
    check("t1_zero", zero, 0);
    check("t1_overrun", overrun, 0);
    step();
    check("t1_hold", result_valid, 1);
    release_word();

    // 2: gapped all-ones word
    begin_word(5'd17);
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        step();
        check($sformatf("t2_busy_%0d_%0d", i, g), busy, 1);
        check($sformatf("t2_nv_%0d_%0d", i, g), result_valid, 0);
      end
      slice(4'hF);
    end
    check("t2_valid", result_valid, 1);
    check("t2_result", result, 32'hFFFF_FFFF);
    check("t2_rd_addr", rd_addr, 17);
    release_word();

    // 3: zero word under backpressure, stray slice in HOLD
    begin_word(5'd1);
    for (int i = 0; i < 8; i++)
      slice(4'h0);
    for (int c = 0; c < 10; c++) begin
      if (c == 4) begin
        slice_in    = 4'hA;
        slice_valid = 1'b1;
      end
      step();
      slice_valid = 1'b0;
      check($sformatf("t3_valid_%0d", c), result_valid, 1);
      check($sformatf("t3_result_%0d", c), result, 0);
      check($sformatf("t3_zero_%0d", c), zero, 1);
    end
    check("t3_overrun", overrun, 1);

    // 4: back-to-back into 0x00000001
    result_ready = 1'b1;
    begin_word(5'd9);
    result_ready = 1'b0;
    check("t4_drop_valid", result_valid, 0);
    check("t4_no_idle", busy, 1);
    w = 32'h0000_0001;
    for (int i = 0; i < 8; i++)
      slice(w[4*i +: 4]);
    check("t4_valid", result_valid, 1);
    check("t4_result", result, 32'h0000_0001);
    check("t4_rd_addr", rd_addr, 9);
    check("t4_zero", zero, 0);
    release_word();

    // 5a: abort after four slices, then a fresh word
    begin_word(5'd3);
    for (int i = 0; i < 4; i++)
      slice(4'h5);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t5_abort_busy", busy, 0);
    check("t5_abort_valid", result_valid, 0);
    check("t5_abort_result", result, 0);
    check("t5_abort_rd", rd_addr, 0);
    check("t5_abort_ovr", overrun, 1);
    w = 32'hCAFE_BABE;
    begin_word(5'd7);
    for (int i = 0; i < 8; i++)
      slice(w[4*i +: 4]);
    check("t5_valid", result_valid, 1);
    check("t5_result", result, 32'hCAFE_BABE);
    check("t5_rd_addr", rd_addr, 7);
    release_word();

    // 5b: asynchronous reset mid-word
    begin_word(5'd12);
    for (int i = 0; i < 3; i++)
      slice(4'h9);
    check("t5_pre_busy", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    check("t5_ar_result", result, 0);
    check("t5_ar_rd", rd_addr, 0);
    check("t5_ar_busy", busy, 0);
    check("t5_ar_ovr", overrun, 0);
    check("t5_ar_valid", result_valid, 0);
    #1;
    reset = 1'b1;
    step();

    // 6: slice with start in IDLE, start during COLLECT
    check("t6_ovr_before", overrun, 0);
    start       = 1'b1;
    rd_addr_in  = 5'd2;
    slice_in    = 4'hF;
    slice_valid = 1'b1;
    step();
    start       = 1'b0;
    slice_valid = 1'b0;
    check("t6_ovr_idle", overrun, 1);
    w = 32'h8765_4321;
    result_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        start      = 1'b1;
        rd_addr_in = 5'd30;
      end
      slice(w[4*i +: 4]);
      start = 1'b0;
    end
    result_ready = 1'b0;
    check("t6_valid", result_valid, 1);
    check("t6_result", result, 32'h8765_4321);
    check("t6_rd_addr", rd_addr, 2);
    release_word();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
